// File: rtl/rsc_frame_encoder.sv
// ----------------------------------------------------------------------------
// rsc_frame_encoder
//   Transmit-side source for the turbo/RSC decoder loopback. Encodes a frame of
//   K info bits with the 8-state recursive systematic convolutional code
//   (g0 = 13, g1 = 15 octal), then appends 3 trellis-termination steps that
//   drive the encoder back to the all-zero state. Every step is presented as a
//   systematic bit, a parity bit and their antipodal soft values.
//
// Parameters
//   K    info bits per frame (>= 1)
//   N    width of the signed soft outputs
//   AMP  soft magnitude: bit 0 -> +AMP, bit 1 -> -AMP
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   in_bit       in   info bit
//   in_valid     in   in_bit valid
//   in_ready     out  in_bit is accepted this cycle when in_valid is high
//   out_sys      out  systematic bit (info bit, or tail input during termination)
//   out_par      out  parity bit
//   out_sys_llr  out  signed soft value of out_sys
//   out_par_llr  out  signed soft value of out_par
//   out_tail     out  current output is a termination step
//   out_last     out  final (third) termination step of the frame
//   out_valid    out  outputs valid
//   out_ready    in   downstream accepts the outputs
// ----------------------------------------------------------------------------
module rsc_frame_encoder #(
    parameter int K   = 40,
    parameter int N   = 5,
    parameter int AMP = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_bit,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_sys,
    output logic                out_par,
    output logic signed [N-1:0] out_sys_llr,
    output logic signed [N-1:0] out_par_llr,
    output logic                out_tail,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int CW = $clog2(K + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    // Antipodal mapping: bit 0 -> +AMP, bit 1 -> -AMP.
    function automatic logic signed [N-1:0] soft_map(input logic b);
        logic signed [N-1:0] mag;
        mag = N'(AMP);
        return b ? -mag : mag;
    endfunction

    state_t              r_state;
    logic                r_d1, r_d2, r_d3;
    logic [CW-1:0]       r_cnt;
    logic [1:0]          r_tcnt;

    logic                r_out_sys;
    logic                r_out_par;
    logic signed [N-1:0] r_out_sys_llr;
    logic signed [N-1:0] r_out_par_llr;
    logic                r_out_tail;
    logic                r_out_last;
    logic                r_out_valid;

    logic                w_slot_free;
    logic                w_accept;
    logic                w_tail_load;
    logic                w_load;
    logic                w_u;
    logic                w_a;
    logic                w_par;

    // The single output slot can take a new step when it is empty or being drained.
    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = w_slot_free && (r_state == S_IDLE || r_state == S_DATA);
    assign w_accept    = in_valid && in_ready;
    assign w_tail_load = w_slot_free && (r_state == S_TAIL);
    assign w_load      = w_accept || w_tail_load;

    // During termination the input is chosen to cancel the feedback (a = 0),
    // flushing zeros into the shift register.
    assign w_u   = (r_state == S_TAIL) ? (r_d2 ^ r_d3) : in_bit;
    assign w_a   = w_u ^ r_d2 ^ r_d3;
    assign w_par = w_a ^ r_d1 ^ r_d3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_d1          <= 1'b0;
            r_d2          <= 1'b0;
            r_d3          <= 1'b0;
            r_cnt         <= '0;
            r_tcnt        <= 2'd0;
            r_out_sys     <= 1'b0;
            r_out_par     <= 1'b0;
            r_out_sys_llr <= '0;
            r_out_par_llr <= '0;
            r_out_tail    <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_valid   <= 1'b0;
        end else begin
            // Output slot and encoder advance together; nothing moves while stalled.
            if (w_load) begin
                r_out_sys     <= w_u;
                r_out_par     <= w_par;
                r_out_sys_llr <= soft_map(w_u);
                r_out_par_llr <= soft_map(w_par);
                r_out_tail    <= (r_state == S_TAIL);
                r_out_last    <= (r_state == S_TAIL) && (r_tcnt == 2'd2);
                r_out_valid   <= 1'b1;
                r_d3          <= r_d2;
                r_d2          <= r_d1;
                r_d1          <= w_a;
            end else if (out_ready) begin
                r_out_valid   <= 1'b0;
            end

            case (r_state)
                S_IDLE, S_DATA: begin
                    if (w_accept) begin
                        if (r_cnt == CW'(K - 1)) begin
                            r_state <= S_TAIL;
                            r_tcnt  <= 2'd0;
                        end else begin
                            r_state <= S_DATA;
                            r_cnt   <= r_cnt + CW'(1);
                        end
                    end
                end
                S_TAIL: begin
                    if (w_tail_load) begin
                        if (r_tcnt == 2'd2) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            r_tcnt  <= 2'd0;
                        end else begin
                            r_tcnt  <= r_tcnt + 2'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_tcnt  <= 2'd0;
                end
            endcase
        end
    end

    assign out_sys     = r_out_sys;
    assign out_par     = r_out_par;
    assign out_sys_llr = r_out_sys_llr;
    assign out_par_llr = r_out_par_llr;
    assign out_tail    = r_out_tail;
    assign out_last    = r_out_last;
    assign out_valid   = r_out_valid;

endmodule

// File: tb/tb_rsc_frame_encoder.sv
module tb_rsc_frame_encoder;

    localparam int K   = 4;
    localparam int N   = 5;
    localparam int AMP = 7;

    localparam logic [N-1:0] LLR_NEG = 5'b11001;
    localparam logic [N-1:0] LLR_POS = 5'b00111;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_bit = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                out_sys;
    logic                out_par;
    logic signed [N-1:0] out_sys_llr;
    logic signed [N-1:0] out_par_llr;
    logic                out_tail;
    logic                out_last;
    logic                out_valid;
    logic                out_ready = 1'b1;

    rsc_frame_encoder #(.K(K), .N(N), .AMP(AMP)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_sys     (out_sys),
        .out_par     (out_par),
        .out_sys_llr (out_sys_llr),
        .out_par_llr (out_par_llr),
        .out_tail    (out_tail),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         sys;
        logic         par;
        logic         tail;
        logic         last;
        logic [N-1:0] sl;
        logic [N-1:0] pl;
    } step_t;

    step_t got[$];
    step_t mon_s;
    int    n_tests = 0;
    int    n_fail  = 0;

    // Hand-computed step sequences, first step in the MSB.
    // Frame A = 1,0,0,0 ; frame B = 1,1,0,1 ; frame Z = 0,0,0,0.
    logic [6:0] A_SYS = 7'b1000101;
    logic [6:0] A_PAR = 7'b1111111;
    logic [6:0] B_SYS = 7'b1101001;
    logic [6:0] B_PAR = 7'b1001011;
    logic [6:0] Z_SYS = 7'b0000000;
    logic [6:0] Z_PAR = 7'b0000000;

    // A transfer happens on the posedge following a negedge with valid & ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_s.sys  = out_sys;
            mon_s.par  = out_par;
            mon_s.tail = out_tail;
            mon_s.last = out_last;
            mon_s.sl   = out_sys_llr;
            mon_s.pl   = out_par_llr;
            got.push_back(mon_s);
        end
    end

    // Present bits MSB-first with in_valid held high until all nb are accepted.
    task automatic drive_bits(input logic [15:0] bits, input int nb, output bit ok);
        int i = 0;
        int guard = 0;
        ok = 1'b1;
        in_valid = 1'b1;
        while (i < nb) begin
            in_bit = bits[nb-1-i];
            @(negedge clk);
            if (in_ready) i++;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 300) begin
                ok = 1'b0;
                break;
            end
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic wait_count(input int n, output bit ok);
        int guard = 0;
        while (got.size() < n && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        ok = (got.size() >= n);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        n_tests++;
        if ({out_sys, out_par, out_tail, out_last, out_sys_llr, out_par_llr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b%b%b%b %b %b exp=all zero",
                     out_sys, out_par, out_tail, out_last, out_sys_llr, out_par_llr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        bit    ok;
        step_t e;
        got.delete();
        drive_bits(16'b1000, 4, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL a_drive_timeout got=timeout exp=4 bits accepted");
        end
        wait_count(7, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL a_count got=%0d exp=7", got.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                e.sys  = A_SYS[6-i];
                e.par  = A_PAR[6-i];
                e.tail = (i >= 4);
                e.last = (i == 6);
                e.sl   = A_SYS[6-i] ? LLR_NEG : LLR_POS;
                e.pl   = A_PAR[6-i] ? LLR_NEG : LLR_POS;
                n_tests++;
                if (got[i] !== e) begin
                    n_fail++;
                    $display("FAIL a_step%0d got=%b exp=%b", i, got[i], e);
                end
            end
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL a_idle_after got=valid%b ready%b exp=valid0 ready1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_frame();
        bit    ok;
        step_t e;
        got.delete();
        drive_bits(16'b0000, 4, ok);
        wait_count(7, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL z_count got=%0d exp=7", got.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                e.sys  = Z_SYS[6-i];
                e.par  = Z_PAR[6-i];
                e.tail = (i >= 4);
                e.last = (i == 6);
                e.sl   = LLR_POS;
                e.pl   = LLR_POS;
                n_tests++;
                if (got[i] !== e) begin
                    n_fail++;
                    $display("FAIL z_step%0d got=%b exp=%b", i, got[i], e);
                end
            end
        end
        n_tests++;
        if ({dut.r_d1, dut.r_d2, dut.r_d3} !== 3'b000) begin
            n_fail++;
            $display("FAIL z_enc_state got=%b exp=000", {dut.r_d1, dut.r_d2, dut.r_d3});
        end
    endtask

    task automatic test_soft_map();
        bit    ok;
        step_t e;
        got.delete();
        drive_bits(16'b1101, 4, ok);
        wait_count(7, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b_count got=%0d exp=7", got.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                e.sys  = B_SYS[6-i];
                e.par  = B_PAR[6-i];
                e.tail = (i >= 4);
                e.last = (i == 6);
                e.sl   = B_SYS[6-i] ? LLR_NEG : LLR_POS;
                e.pl   = B_PAR[6-i] ? LLR_NEG : LLR_POS;
                n_tests++;
                if (got[i] !== e) begin
                    n_fail++;
                    $display("FAIL b_step%0d got=%b exp=%b", i, got[i], e);
                end
            end
            // Step 0 is sys=1/par=1, step 2 is sys=0: explicit encodings.
            n_tests++;
            if (got[0].sl !== 5'b11001) begin
                n_fail++;
                $display("FAIL llr_one got=%b exp=11001", got[0].sl);
            end
            n_tests++;
            if (got[2].sl !== 5'b00111) begin
                n_fail++;
                $display("FAIL llr_zero got=%b exp=00111", got[2].sl);
            end
        end
    endtask

    task automatic test_stall();
        bit    ok_d;
        bit    ok;
        step_t e;
        step_t snap;
        int    guard;
        got.delete();
        fork
            drive_bits(16'b1000, 4, ok_d);
            begin
                guard = 0;
                while (got.size() < 2 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    if (c == 0) begin
                        snap = {out_sys, out_par, out_tail, out_last, out_sys_llr, out_par_llr};
                        n_tests++;
                        if (snap !== {A_SYS[4], A_PAR[4], 1'b0, 1'b0,
                                      A_SYS[4] ? LLR_NEG : LLR_POS, A_PAR[4] ? LLR_NEG : LLR_POS}) begin
                            n_fail++;
                            $display("FAIL stall_step2 got=%b exp=step 2 of frame A", snap);
                        end
                    end else begin
                        n_tests++;
                        if ({out_sys, out_par, out_tail, out_last, out_sys_llr, out_par_llr} !== snap) begin
                            n_fail++;
                            $display("FAIL stall_hold%0d got=%b exp=%b", c,
                                     {out_sys, out_par, out_tail, out_last, out_sys_llr, out_par_llr}, snap);
                        end
                    end
                    n_tests++;
                    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_hs%0d got=valid%b ready%b exp=valid1 ready0", c, out_valid, in_ready);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_count(7, ok);
        n_tests++;
        if (!ok || !ok_d) begin
            n_fail++;
            $display("FAIL s_count got=%0d exp=7", got.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                e.sys  = A_SYS[6-i];
                e.par  = A_PAR[6-i];
                e.tail = (i >= 4);
                e.last = (i == 6);
                e.sl   = A_SYS[6-i] ? LLR_NEG : LLR_POS;
                e.pl   = A_PAR[6-i] ? LLR_NEG : LLR_POS;
                n_tests++;
                if (got[i] !== e) begin
                    n_fail++;
                    $display("FAIL s_step%0d got=%b exp=%b", i, got[i], e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit    ok;
        step_t e;
        got.delete();
        drive_bits({8'd0, 4'b1000, 4'b1101}, 8, ok);
        wait_count(14, ok);
        n_tests++;
        if (!ok || got.size() != 14) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d exp=14", got.size());
        end else begin
            for (int i = 0; i < 14; i++) begin
                int j;
                j = i % 7;
                e.sys  = (i < 7) ? A_SYS[6-j] : B_SYS[6-j];
                e.par  = (i < 7) ? A_PAR[6-j] : B_PAR[6-j];
                e.tail = (j >= 4);
                e.last = (j == 6);
                e.sl   = e.sys ? LLR_NEG : LLR_POS;
                e.pl   = e.par ? LLR_NEG : LLR_POS;
                n_tests++;
                if (got[i] !== e) begin
                    n_fail++;
                    $display("FAIL b2b_step%0d got=%b exp=%b", i, got[i], e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit    ok;
        step_t e;
        drive_bits(16'b11, 2, ok);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_hs got=valid%b ready%b exp=valid0 ready1", out_valid, in_ready);
        end
        n_tests++;
        if ({out_sys, out_par, out_tail, out_last, out_sys_llr, out_par_llr} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got=%b%b%b%b %b %b exp=all zero",
                     out_sys, out_par, out_tail, out_last, out_sys_llr, out_par_llr);
        end
        @(posedge clk);
        #1;
        got.delete();
        drive_bits(16'b1000, 4, ok);
        wait_count(7, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_count got=%0d exp=7", got.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                e.sys  = A_SYS[6-i];
                e.par  = A_PAR[6-i];
                e.tail = (i >= 4);
                e.last = (i == 6);
                e.sl   = A_SYS[6-i] ? LLR_NEG : LLR_POS;
                e.pl   = A_PAR[6-i] ? LLR_NEG : LLR_POS;
                n_tests++;
                if (got[i] !== e) begin
                    n_fail++;
                    $display("FAIL rstmid_step%0d got=%b exp=%b", i, got[i], e);
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_frame();
        test_zero_frame();
        test_soft_map();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
